// File: rtl/rr_arb3_ctrl.sv
// rr_arb3_ctrl: three-requester round-robin arbiter with one-cycle idle gap between tenures.
//
// Ports:
//   CK     - clock; all state changes on the rising edge
//   RN     - asynchronous active-low reset
//   REQ    - [2:0] level requests; held high for the whole tenure
//   GNT    - [2:0] registered one-hot grant, zero when idle
//   OWNER  - [1:0] index of the granted requester, 2'd3 when idle
//   BUSY   - high while a grant is held
//   TO     - one-cycle pulse on a forced (timed-out) release
//
// Parameters:
//   TIMEOUT_CYCLES - max consecutive GRANT cycles per tenure (2..31)
//   CNT_W          - tenure counter width; must hold TIMEOUT_CYCLES
//
// Optional feature: define ARB_TIMEOUT_EN to bound tenure length. Without it
// tenure is unbounded and TO is tied low.
module rr_arb3_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic       CK,
  input  logic       RN,
  input  logic [2:0] REQ,
  output logic [2:0] GNT,
  output logic [1:0] OWNER,
  output logic       BUSY,
  output logic       TO
);

  // Reject configurations the counter cannot represent.
  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 31) ||
      (TIMEOUT_CYCLES > ((1 << CNT_W) - 1))) begin : g_cfg_check
    $error("rr_arb3_ctrl: TIMEOUT_CYCLES out of range for CNT_W");
  end

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q;
  logic [1:0] ptr_q;
  logic [2:0] gnt_q;
  logic [1:0] owner_q;
  logic       busy_q;

  logic [1:0] cand0, cand1, pick_idx;
  logic       owner_req;
  logic       timeout_hit;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    case (i)
      2'd0:    next_idx = 2'd1;
      2'd1:    next_idx = 2'd2;
      default: next_idx = 2'd0;
    endcase
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    case (i)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      default: onehot = 3'b100;
    endcase
  endfunction

  // Search order after the last owner: ptr+1, ptr+2, ptr.
  always_comb begin
    cand0    = next_idx(ptr_q);
    cand1    = next_idx(cand0);
    pick_idx = ptr_q;
    if (|(REQ & onehot(cand0))) begin
      pick_idx = cand0;
    end else if (|(REQ & onehot(cand1))) begin
      pick_idx = cand1;
    end
  end

  // Current owner's request, found through the one-hot grant to avoid indexing by 2'd3.
  assign owner_req = |(REQ & gnt_q);

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= StIdle;
      ptr_q   <= 2'd2;
      gnt_q   <= 3'b000;
      owner_q <= 2'd3;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|REQ) begin
            state_q <= StGrant;
            gnt_q   <= onehot(pick_idx);
            owner_q <= pick_idx;
            busy_q  <= 1'b1;
          end
        end
        StGrant: begin
          if (!owner_req || timeout_hit) begin
            state_q <= StIdle;
            ptr_q   <= owner_q;
            gnt_q   <= 3'b000;
            owner_q <= 2'd3;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             to_q;

  assign timeout_hit = (state_q == StGrant) && (cnt_q == CntLast);

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      to_q <= 1'b0;
      if (state_q == StIdle) begin
        cnt_q <= '0;
      end else if (!owner_req || timeout_hit) begin
        cnt_q <= '0;
        // A normal release on the timeout edge wins: no pulse.
        to_q  <= owner_req;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign TO = to_q;
`else
  assign timeout_hit = 1'b0;
  assign TO          = 1'b0;
`endif

  assign GNT   = gnt_q;
  assign OWNER = owner_q;
  assign BUSY  = busy_q;

endmodule
